// File: rtl/udp_row_packetizer.sv
// Ethernet-side row packetizer: buffers one payload burst in a packet RAM, then streams
// an 8-byte application header followed by the payload toward the UDP/IP TX stack.
//   state   | meaning
//   IDLE    | waiting for the first payload beat
//   COLLECT | writing the burst into the packet RAM
//   SETTLE  | grace window in which i_packet_last may still arrive
//   HEADER  | streaming the 8 header bytes
//   PAYLOAD | streaming RAM[0..cnt-1]
module udp_row_packetizer #(
  parameter int         MAX_PAYLOAD = 1469,
  parameter int         RAM_AW      = 11,
  parameter int         LAST_WAIT   = 4,
  parameter logic [7:0] MAGIC       = 8'hA5
) (
  input  logic        i_read_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [14:0] i_data_byte,
  input  logic [7:0]  i_row_number,
  input  logic [7:0]  i_rgb_data,
  input  logic        i_sof,
  input  logic        i_packet_last,
  output logic        o_eth_busy,
  output logic [7:0]  o_tdata,
  output logic        o_tvalid,
  input  logic        i_tready,
  output logic        o_tlast,
  output logic        o_tuser,
  output logic [15:0] o_frame_id,
  output logic        o_len_err,
  output logic        o_drop_err
);

  localparam int WW = (LAST_WAIT > 1) ? $clog2(LAST_WAIT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_SETTLE, S_HEADER, S_PAYLOAD} state_t;

  state_t        state_q, state_d;
  logic [14:0]   len_q, len_d;
  logic [7:0]    row_q, row_d;
  logic          sof_q, sof_d;
  logic          last_f_q, last_f_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [2:0]    hdr_idx_q, hdr_idx_d;
  logic [15:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]    pkt_idx_q, pkt_idx_d;
  logic [7:0]    last_row_q, last_row_d;
  logic [15:0]   frame_id_q, frame_id_d;
  logic          len_err_q, len_err_d;
  logic          drop_err_q, drop_err_d;

  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr;
  logic [7:0]        ram_rdata_q;
  logic [7:0]        ram_mem [2**RAM_AW];
  logic [7:0]        hdr_byte;
  logic              hs;

  // Reading at rd_ptr_d keeps ram_rdata_q == RAM[rd_ptr_q]: it acts as the prefetch
  // register, so payload bytes follow the header and stalls without bubbles.
  always_ff @(posedge i_read_clk) begin
    if (ram_we) ram_mem[ram_waddr] <= i_rgb_data;
    ram_rdata_q <= ram_mem[rd_ptr_d[RAM_AW-1:0]];
  end

  always_comb begin
    case (hdr_idx_q)
      3'd0:    hdr_byte = frame_id_q[15:8];
      3'd1:    hdr_byte = frame_id_q[7:0];
      3'd2:    hdr_byte = row_q;
      3'd3:    hdr_byte = pkt_idx_q;
      3'd4:    hdr_byte = cnt_q[15:8];
      3'd5:    hdr_byte = cnt_q[7:0];
      3'd6:    hdr_byte = {6'b0, last_f_q, sof_q};
      default: hdr_byte = MAGIC;
    endcase
  end

  assign o_eth_busy = (state_q != S_IDLE);
  assign o_tvalid   = (state_q == S_HEADER) || (state_q == S_PAYLOAD);
  assign o_tdata    = (state_q == S_HEADER)  ? hdr_byte :
                      (state_q == S_PAYLOAD) ? ram_rdata_q : 8'h00;
  assign o_tlast    = (state_q == S_PAYLOAD) && (rd_ptr_q == cnt_q - 16'd1);
  assign o_tuser    = (state_q == S_HEADER) && (hdr_idx_q == 3'd0) && sof_q;
  assign o_frame_id = frame_id_q;
  assign o_len_err  = len_err_q;
  assign o_drop_err = drop_err_q;
  assign hs         = o_tvalid && i_tready;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    row_d      = row_q;
    sof_d      = sof_q;
    last_f_d   = last_f_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    hdr_idx_d  = hdr_idx_q;
    rd_ptr_d   = '0;
    pkt_idx_d  = pkt_idx_q;
    last_row_d = last_row_q;
    frame_id_d = frame_id_q;
    len_err_d  = 1'b0;
    drop_err_d = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = cnt_q[RAM_AW-1:0];
    case (state_q)
      S_IDLE: begin
        last_f_d = 1'b0;
        if (i_valid) begin
          len_d     = i_data_byte;
          row_d     = i_row_number;
          sof_d     = i_sof;
          ram_we    = 1'b1;
          ram_waddr = '0;
          cnt_d     = 16'd1;
          state_d   = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (i_packet_last) last_f_d = 1'b1;
        if (i_valid) begin
          if (cnt_q < 16'(MAX_PAYLOAD)) begin
            ram_we = 1'b1;
            cnt_d  = cnt_q + 16'd1;
          end else begin
            drop_err_d = 1'b1;
          end
        end else begin
          wait_d  = WW'(LAST_WAIT - 1);
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (i_packet_last) last_f_d = 1'b1;
        if (i_valid) drop_err_d = 1'b1;
        if (wait_q == '0) begin
          hdr_idx_d = '0;
          len_err_d = (cnt_q != {1'b0, len_q});
          pkt_idx_d = (row_q != last_row_q) ? 8'h00 : pkt_idx_q + 8'h01;
          state_d   = S_HEADER;
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      S_HEADER: begin
        if (i_valid) drop_err_d = 1'b1;
        if (hs) begin
          if (hdr_idx_q == 3'd7) state_d = S_PAYLOAD;
          else hdr_idx_d = hdr_idx_q + 3'd1;
        end
      end
      S_PAYLOAD: begin
        if (i_valid) drop_err_d = 1'b1;
        rd_ptr_d = hs ? rd_ptr_q + 16'd1 : rd_ptr_q;
        if (hs && o_tlast) begin
          state_d    = S_IDLE;
          last_row_d = row_q;
          if (last_f_q) begin
            frame_id_d = frame_id_q + 16'd1;
            pkt_idx_d  = 8'h00;
            last_row_d = 8'hFF;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_read_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      row_q      <= '0;
      sof_q      <= 1'b0;
      last_f_q   <= 1'b0;
      cnt_q      <= '0;
      wait_q     <= '0;
      hdr_idx_q  <= '0;
      rd_ptr_q   <= '0;
      pkt_idx_q  <= '0;
      last_row_q <= 8'hFF;
      frame_id_q <= '0;
      len_err_q  <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      row_q      <= row_d;
      sof_q      <= sof_d;
      last_f_q   <= last_f_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      hdr_idx_q  <= hdr_idx_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_idx_q  <= pkt_idx_d;
      last_row_q <= last_row_d;
      frame_id_q <= frame_id_d;
      len_err_q  <= len_err_d;
      drop_err_q <= drop_err_d;
    end
  end

endmodule

// File: tb/tb_udp_row_packetizer.sv
// Bench for udp_row_packetizer: random payload bursts compared against a packet-level
// model of the header rules, frame counter and packet index.
module tb_udp_row_packetizer;
  localparam int MAX_PAYLOAD = 1469;
  localparam int LAST_WAIT   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [14:0] data_byte = '0;
  logic [7:0]  row_number = '0;
  logic [7:0]  rgb_data = '0;
  logic        sof = 1'b0;
  logic        packet_last = 1'b0;
  logic        tready = 1'b1;
  logic        eth_busy, tvalid, tlast, tuser, len_err, drop_err;
  logic [7:0]  tdata;
  logic [15:0] frame_id;

  always #4 clk = ~clk;

  udp_row_packetizer dut (
    .i_read_clk(clk), .i_rst(rst), .i_valid(valid), .i_data_byte(data_byte),
    .i_row_number(row_number), .i_rgb_data(rgb_data), .i_sof(sof),
    .i_packet_last(packet_last), .o_eth_busy(eth_busy), .o_tdata(tdata),
    .o_tvalid(tvalid), .i_tready(tready), .o_tlast(tlast), .o_tuser(tuser),
    .o_frame_id(frame_id), .o_len_err(len_err), .o_drop_err(drop_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drop_cnt = 0;
  int len_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (drop_err === 1'b1) drop_cnt <= drop_cnt + 1;
    if (len_err === 1'b1) len_cnt <= len_cnt + 1;
  end

  // packet-level reference state
  logic [15:0] m_frame;
  logic [7:0]  m_idx, m_last_row;
  logic [7:0]  exp_q[$];
  logic        exp_sof;
  int          exp_len_err, exp_drops, drop0, len0, last_edge;
  logic [7:0]  got_hdr[8];

  task automatic model_reset();
    m_frame = 16'h0000;
    m_idx = 8'h00;
    m_last_row = 8'hFF;
  endtask

  task automatic send_packet(input int beats, input int ann_len, input logic [7:0] row,
                             input logic s, input int last_delay);
    logic [7:0] pay[$];
    int n_kept;
    logic [15:0] c16;
    logic lf;
    n_kept = (beats > MAX_PAYLOAD) ? MAX_PAYLOAD : beats;
    c16 = 16'(n_kept);
    lf = (last_delay >= 0);
    m_idx = (row != m_last_row) ? 8'h00 : m_idx + 8'h01;
    for (int i = 0; i < beats; i++) pay.push_back(8'($urandom));
    exp_q = {};
    exp_q.push_back(m_frame[15:8]);
    exp_q.push_back(m_frame[7:0]);
    exp_q.push_back(row);
    exp_q.push_back(m_idx);
    exp_q.push_back(c16[15:8]);
    exp_q.push_back(c16[7:0]);
    exp_q.push_back({6'b0, lf, s});
    exp_q.push_back(8'hA5);
    for (int i = 0; i < n_kept; i++) exp_q.push_back(pay[i]);
    exp_sof = s;
    exp_len_err = (n_kept != ann_len) ? 1 : 0;
    exp_drops = beats - n_kept;
    m_last_row = row;
    if (lf) begin
      m_frame = m_frame + 16'd1;
      m_idx = 8'h00;
      m_last_row = 8'hFF;
    end
    drop0 = drop_cnt;
    len0 = len_cnt;
    for (int i = 0; i < beats; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (eth_busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_before_burst got %b want 0", eth_busy);
        end
      end
      if (i == 1) begin
        checks++;
        if (eth_busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_after_first_beat got %b want 1", eth_busy);
        end
      end
      valid = 1'b1;
      rgb_data = pay[i];
      if (i == 0) begin
        data_byte = 15'(ann_len);
        row_number = row;
        sof = s;
      end else begin
        data_byte = 15'($urandom);
        row_number = 8'($urandom);
        sof = 1'($urandom);
      end
    end
    @(negedge clk);
    valid = 1'b0;
    last_edge = cyc;
    if (lf) begin
      repeat (last_delay) @(negedge clk);
      packet_last = 1'b1;
      @(negedge clk);
      packet_last = 1'b0;
    end
  endtask

  task automatic recv_packet(input int rdy_pct, input int abort_after, input int inject);
    int n, sz, budget, c, first_cyc, bad_idx, stall_bad, busy_bad, flag_bad, injected;
    logic done, stalled, pl, pu;
    logic [7:0] pd;
    n = 0; c = 0; first_cyc = -1; bad_idx = -1; stall_bad = 0; busy_bad = 0;
    flag_bad = 0; injected = 0; done = 1'b0; stalled = 1'b0; pl = 1'b0; pu = 1'b0; pd = '0;
    sz = exp_q.size();
    budget = 4 * sz + 200;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
      tready = ($urandom_range(99) < rdy_pct);
      if (injected < inject && first_cyc >= 0) begin
        valid = 1'b1;
        rgb_data = 8'($urandom);
        injected++;
      end else begin
        valid = 1'b0;
      end
      if (eth_busy !== 1'b1) busy_bad++;
      if (tvalid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (stalled && (tdata !== pd || tlast !== pl || tuser !== pu)) stall_bad++;
        if (tready) begin
          if (n < 8) got_hdr[n] = tdata;
          if (n >= sz || tdata !== exp_q[n]) begin
            if (bad_idx < 0) bad_idx = n;
          end
          if (tlast !== (n == sz - 1)) flag_bad++;
          if (tuser !== ((n == 0) && exp_sof)) flag_bad++;
          n++;
          if (tlast === 1'b1) done = 1'b1;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pd = tdata; pl = tlast; pu = tuser;
        end
      end
      if (abort_after > 0 && n >= abort_after) break;
    end
    valid = 1'b0;
    if (abort_after > 0) return;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL stream_timeout got %0d bytes want %0d", n, sz);
    end
    checks++;
    if (first_cyc - last_edge !== LAST_WAIT + 1) begin
      errors++;
      $display("FAIL header_latency got %0d want %0d", first_cyc - last_edge, LAST_WAIT + 1);
    end
    checks++;
    if (bad_idx !== -1) begin
      errors++;
      $display("FAIL stream_bytes first bad index got %0d want -1", bad_idx);
    end
    checks++;
    if (n !== sz) begin
      errors++;
      $display("FAIL stream_length got %0d want %0d", n, sz);
    end
    checks++;
    if (flag_bad !== 0) begin
      errors++;
      $display("FAIL tlast_tuser_flags got %0d bad want 0", flag_bad);
    end
    checks++;
    if (stall_bad !== 0) begin
      errors++;
      $display("FAIL stall_stable got %0d changes want 0", stall_bad);
    end
    checks++;
    if (busy_bad !== 0) begin
      errors++;
      $display("FAIL busy_during_packet got %0d low cycles want 0", busy_bad);
    end
    @(negedge clk);
    checks++;
    if (eth_busy !== 1'b0 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_tlast got busy=%b tvalid=%b want 0 0", eth_busy, tvalid);
    end
    checks++;
    if (frame_id !== m_frame) begin
      errors++;
      $display("FAIL frame_id got %h want %h", frame_id, m_frame);
    end
    @(negedge clk);
    checks++;
    if (len_cnt - len0 !== exp_len_err) begin
      errors++;
      $display("FAIL len_err_pulses got %0d want %0d", len_cnt - len0, exp_len_err);
    end
    checks++;
    if (drop_cnt - drop0 !== exp_drops + inject) begin
      errors++;
      $display("FAIL drop_err_pulses got %0d want %0d", drop_cnt - drop0, exp_drops + inject);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tvalid, tlast, tuser, tdata} !== 11'h0) begin
      errors++;
      $display("FAIL reset_stream got %b%b%b %h want 0", tvalid, tlast, tuser, tdata);
    end
    checks++;
    if (eth_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", eth_busy);
    end
    checks++;
    if (frame_id !== 16'h0000) begin
      errors++;
      $display("FAIL reset_frame got %h want 0000", frame_id);
    end
    checks++;
    if ({len_err, drop_err} !== 2'b00) begin
      errors++;
      $display("FAIL reset_errs got %b%b want 00", len_err, drop_err);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_row0();
    logic [7:0] want[8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h82, 8'h01, 8'hA5};
    send_packet(1410, 1410, 8'd0, 1'b1, -1);
    recv_packet(100, 0, 0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_hdr[i] !== want[i]) begin
        errors++;
        $display("FAIL row0_header[%0d] got %h want %h", i, got_hdr[i], want[i]);
      end
    end
  endtask

  task automatic test_pkt_index();
    int lens[4] = '{1410, 1410, 300, 300};
    logic [7:0] rows[4] = '{8'd5, 8'd5, 8'd5, 8'd6};
    logic [7:0] idxw[4] = '{8'd0, 8'd1, 8'd2, 8'd0};
    for (int k = 0; k < 4; k++) begin
      send_packet(lens[k], lens[k], rows[k], 1'b0, -1);
      recv_packet(100, 0, 0);
      checks++;
      if (got_hdr[3] !== idxw[k]) begin
        errors++;
        $display("FAIL pkt_idx[%0d] got %h want %h", k, got_hdr[3], idxw[k]);
      end
      checks++;
      if ({got_hdr[4], got_hdr[5]} !== 16'(lens[k])) begin
        errors++;
        $display("FAIL pkt_len[%0d] got %h%h want %h", k, got_hdr[4], got_hdr[5], 16'(lens[k]));
      end
    end
  endtask

  task automatic test_frame_last();
    send_packet(120, 120, 8'd89, 1'b0, 2);
    recv_packet(100, 0, 0);
    checks++;
    if (got_hdr[6] !== 8'h02) begin
      errors++;
      $display("FAIL last_flag_byte got %h want 02", got_hdr[6]);
    end
    checks++;
    if (frame_id !== 16'h0001) begin
      errors++;
      $display("FAIL frame_increment got %h want 0001", frame_id);
    end
    @(negedge clk);
    packet_last = 1'b1;
    @(negedge clk);
    packet_last = 1'b0;
    send_packet(40, 40, 8'd90, 1'b0, -1);
    recv_packet(100, 0, 0);
    checks++;
    if ({got_hdr[0], got_hdr[1], got_hdr[6]} !== 24'h000100) begin
      errors++;
      $display("FAIL next_frame_header got %h%h %h want 0001 00", got_hdr[0], got_hdr[1], got_hdr[6]);
    end
  endtask

  task automatic test_random_ready();
    send_packet(100, 100, 8'($urandom_range(30, 80)), 1'b1, -1);
    recv_packet(50, 0, 3);
  endtask

  task automatic test_len_err();
    send_packet(198, 200, 8'd7, 1'b0, -1);
    recv_packet(100, 0, 0);
    checks++;
    if ({got_hdr[4], got_hdr[5]} !== 16'h00C6) begin
      errors++;
      $display("FAIL short_len_field got %h%h want 00C6", got_hdr[4], got_hdr[5]);
    end
    send_packet(1500, 1500, 8'd7, 1'b0, -1);
    recv_packet(100, 0, 0);
    checks++;
    if ({got_hdr[4], got_hdr[5]} !== 16'h05BD) begin
      errors++;
      $display("FAIL long_len_field got %h%h want 05BD", got_hdr[4], got_hdr[5]);
    end
  endtask

  task automatic test_exact_max();
    send_packet(MAX_PAYLOAD, MAX_PAYLOAD, 8'd8, 1'b0, -1);
    recv_packet(100, 0, 0);
    checks++;
    if ({got_hdr[4], got_hdr[5]} !== 16'h05BD) begin
      errors++;
      $display("FAIL max_len_field got %h%h want 05BD", got_hdr[4], got_hdr[5]);
    end
  endtask

  task automatic test_reset_mid();
    send_packet(300, 300, 8'd12, 1'b1, -1);
    recv_packet(100, 20, 0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tvalid !== 1'b0 || eth_busy !== 1'b0 || tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort got tvalid=%b busy=%b tlast=%b want 0 0 0", tvalid, eth_busy, tlast);
    end
    checks++;
    if (frame_id !== 16'h0000) begin
      errors++;
      $display("FAIL reset_abort_frame got %h want 0000", frame_id);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    send_packet(60, 60, 8'd12, 1'b0, -1);
    recv_packet(100, 0, 0);
    checks++;
    if ({got_hdr[0], got_hdr[1], got_hdr[3]} !== 24'h000000) begin
      errors++;
      $display("FAIL post_reset_header got %h%h idx %h want 0000 00", got_hdr[0], got_hdr[1], got_hdr[3]);
    end
  endtask

  task automatic test_back_to_back();
    int beats, ann, ld;
    for (int k = 0; k < 6; k++) begin
      beats = $urandom_range(2, 200);
      ann = beats + int'($urandom_range(0, 1));
      ld = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      send_packet(beats, ann, 8'($urandom_range(20, 22)), 1'($urandom), ld);
      recv_packet(70, 0, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_row0();
    test_pkt_index();
    test_frame_last();
    test_random_ready();
    test_len_err();
    test_exact_max();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
